// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the character LCD write controller.
//   state_t       FSM state encoding
//   CMD_CLEAR/HOME command bytes that need the long execution wait
//   is_long_cmd() picks the long wait for clear/home commands
//   max4()        helper for sizing the shared timer
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POR   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SETUP = 3'd2,
    ST_EN_HI = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  // The controller ignores DB0 when decoding Return Home, so 8'h03 is also a home.
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == CMD_HOME_ALT));
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// lcd_ctrl_if: byte handshake from the sequencer plus the LCD pin bundle.
//   in_valid/in_ready/in_rs/in_data  byte offer and acceptance
//   lcd_db/lcd_rs/lcd_rw/lcd_en      LCD pins
//   busy                             inverse of in_ready
// master = sequencer side, slave = controller side.
interface lcd_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic [7:0] lcd_db;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       busy;

  modport master (
    output in_valid, in_rs, in_data,
    input  in_ready, busy, lcd_db, lcd_rs, lcd_rw, lcd_en
  );

  modport slave (
    input  in_valid, in_rs, in_data,
    output in_ready, busy, lcd_db, lcd_rs, lcd_rw, lcd_en
  );
endinterface

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter shared by every controller state.
//   clk, rst     clock, asynchronous active-high reset
//   i_load       load i_load_val this cycle (takes priority over counting)
//   i_load_val   value to load (state length minus one)
//   o_done       counter has reached zero
// The counter saturates at zero, so it can never wrap.
module lcd_timer #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-style character LCD write controller.
//   clk, rst   clock, asynchronous active-high reset
//   ctrl_bus   lcd_ctrl_if.slave: byte handshake in, LCD pins out
// Each accepted byte is placed on the bus, held for T_SETUP_CYC cycles with
// EN low, strobed for T_EN_CYC cycles, then followed by an execution wait
// (T_LONG_CYC for clear/home, T_CMD_CYC otherwise). In 4-bit mode the high
// nibble goes first on lcd_db[7:4], then the low nibble. All outputs come
// straight from flops.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_POR_CYC   = 15000,
  parameter int T_SETUP_CYC = 1,
  parameter int T_EN_CYC    = 1,
  parameter int T_CMD_CYC   = 40,
  parameter int T_LONG_CYC  = 1640,
  parameter int BUS_4BIT    = 0
) (
  input  logic       clk,
  input  logic       rst,
  lcd_ctrl_if.slave  ctrl_bus
);

  // One extra bit so the power-on count itself (not count-1) fits.
  localparam int CW = $clog2(max4(T_POR_CYC, T_SETUP_CYC, T_CMD_CYC,
                                  max4(T_LONG_CYC, T_EN_CYC, 1, 1))) + 1;

  localparam logic [CW-1:0] L_POR   = CW'(T_POR_CYC);
  localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP_CYC - 1);
  localparam logic [CW-1:0] L_EN    = CW'(T_EN_CYC - 1);
  localparam logic [CW-1:0] L_CMD   = CW'(T_CMD_CYC - 1);
  localparam logic [CW-1:0] L_LONG  = CW'(T_LONG_CYC - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [7:0]    r_data;
  logic          r_rs;
  logic          r_nib_hi;
  logic [7:0]    r_db;
  logic          r_en;
  logic          r_ready;
  logic          r_busy;

  logic          w_accept;
  logic          w_timer_done;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_nib_hi_next;
  logic [7:0]    w_db_next;
  logic          w_en_next;
  logic          w_ready_next;
  logic [7:0]    w_db_first;
  logic          w_nib_first;

  assign w_accept = (r_state == ST_IDLE) && ctrl_bus.in_valid;

  // First bus value of a transfer: whole byte, or high nibble in 4-bit mode.
  generate
    if (BUS_4BIT != 0) begin : g_bus4
      assign w_db_first  = {ctrl_bus.in_data[7:4], 4'h0};
      assign w_nib_first = 1'b1;
    end else begin : g_bus8
      assign w_db_first  = ctrl_bus.in_data;
      assign w_nib_first = 1'b0;
    end
  endgenerate

  // Power-on starts with the full count (not count-1) so that in_ready rises
  // T_POR_CYC cycles after the first edge following reset release.
  lcd_timer #(
    .W       (CW),
    .RST_VAL (L_POR)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_timer_done)
  );

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_POR;
      r_data   <= 8'h00;
      r_rs     <= 1'b0;
      r_nib_hi <= 1'b0;
      r_db     <= 8'h00;
      r_en     <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_data <= ctrl_bus.in_data;
        r_rs   <= ctrl_bus.in_rs;
      end
      r_nib_hi <= w_nib_hi_next;
      r_db     <= w_db_next;
      r_en     <= w_en_next;
      r_ready  <= w_ready_next;
      r_busy   <= ~w_ready_next;
    end
  end

  // Next state and timer reload
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_POR:   if (w_timer_done) w_state_next = ST_IDLE;
      ST_IDLE:  if (w_accept)     w_state_next = ST_SETUP;
      ST_SETUP: if (w_timer_done) w_state_next = ST_EN_HI;
      ST_EN_HI: if (w_timer_done) w_state_next = r_nib_hi ? ST_SETUP : ST_WAIT;
      ST_WAIT:  if (w_timer_done) w_state_next = ST_IDLE;
      default:  w_state_next = ST_POR;
    endcase

    // Every state change reloads the shared timer with the new state's length.
    w_load = (w_state_next != r_state);
    case (w_state_next)
      ST_SETUP: w_load_val = L_SETUP;
      ST_EN_HI: w_load_val = L_EN;
      ST_WAIT:  w_load_val = is_long_cmd(r_rs, r_data) ? L_LONG : L_CMD;
      default:  w_load_val = '0;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_nib_hi_next = r_nib_hi;
    w_db_next     = r_db;
    if (w_accept) begin
      w_nib_hi_next = w_nib_first;
      w_db_next     = w_db_first;
    end else if ((r_state == ST_EN_HI) && (w_state_next == ST_SETUP)) begin
      w_nib_hi_next = 1'b0;
      w_db_next     = {r_data[3:0], 4'h0};
    end
    w_en_next    = (w_state_next == ST_EN_HI);
    w_ready_next = (w_state_next == ST_IDLE);
  end

  assign ctrl_bus.lcd_db   = r_db;
  assign ctrl_bus.lcd_rs   = r_rs;
  assign ctrl_bus.lcd_rw   = 1'b0;
  assign ctrl_bus.lcd_en   = r_en;
  assign ctrl_bus.in_ready = r_ready;
  assign ctrl_bus.busy     = r_busy;

endmodule
